// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage that sits in front of decode. It owns the PC,
//   issues word requests to instruction memory (req/ack, wait states allowed),
//   and hands each returned word plus its address to decode over valid/ready.
//   Execute can redirect the stream with a single-cycle taken-branch pulse,
//   and a level halt stops new fetches while the output still drains. A
//   one-entry skid buffer catches a word that returns while decode stalls.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset (0 = in reset)
//   in_mem       instruction word, valid when in_mem_ack=1
//   in_mem_ack   memory completes the outstanding request this cycle
//   in_mem_addr  fetch address (always the current pc, word aligned)
//   in_mem_en    fetch request, high only in FETCH and FLUSH
//   br_taken     redirect pulse from execute
//   br_target    redirect address, bits [1:0] forced to 0
//   halt         level, stop issuing new fetches
//   instr_ready  decode accepts instr this cycle
//   instr        fetched instruction
//   instr_pc     address of instr
//   instr_valid  instr/instr_pc valid
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_mem,
  input  logic        in_mem_ack,
  output logic [31:0] in_mem_addr,
  output logic        in_mem_en,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        halt,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    FLUSH,
    HOLD,
    HALTED
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  // Redirect target parked while a flushed request is still outstanding; the
  // pc itself keeps driving the old address so en/addr stay stable until ack.
  logic [31:0] flush_pc, flush_pc_nxt;
  logic [31:0] instr_nxt, instr_pc_nxt;
  logic        instr_valid_nxt;
  logic        skid_valid, skid_valid_nxt;
  logic [31:0] skid_instr, skid_pc;
  logic        skid_load;
  logic [31:0] br_pc;
  logic        out_xfer;

  assign br_pc       = {br_target[31:2], 2'b00};
  assign out_xfer    = instr_valid & instr_ready;
  assign in_mem_addr = pc;
  assign in_mem_en   = (state == FETCH) || (state == FLUSH);

  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // through the case statement leaves a signal unassigned (no latches).
    state_nxt       = state;
    pc_nxt          = pc;
    flush_pc_nxt    = flush_pc;
    instr_nxt       = instr;
    instr_pc_nxt    = instr_pc;
    instr_valid_nxt = instr_valid & ~out_xfer;  // drain unless reloaded below
    skid_valid_nxt  = skid_valid;
    skid_load       = 1'b0;

    case (state)
      IDLE: begin
        if (br_taken) pc_nxt = br_pc;
        state_nxt = halt ? HALTED : FETCH;
      end

      FETCH: begin
        if (br_taken) begin
          instr_valid_nxt = 1'b0;
          skid_valid_nxt  = 1'b0;
          if (in_mem_ack) begin
            // Returned word is dropped; request the target next cycle.
            pc_nxt    = br_pc;
            state_nxt = FETCH;
          end else begin
            flush_pc_nxt = br_pc;
            state_nxt    = FLUSH;
          end
        end else if (in_mem_ack) begin
          pc_nxt = pc + PC_STEP;
          if (!instr_valid || instr_ready) begin
            instr_nxt       = in_mem;
            instr_pc_nxt    = pc;
            instr_valid_nxt = 1'b1;
            state_nxt       = halt ? HALTED : FETCH;
          end else begin
            skid_load      = 1'b1;
            skid_valid_nxt = 1'b1;
            state_nxt      = HOLD;
          end
        end
        // ack=0: request stays outstanding, halt waits for its completion.
      end

      FLUSH: begin
        instr_valid_nxt = 1'b0;
        if (br_taken) flush_pc_nxt = br_pc;
        if (in_mem_ack) begin
          pc_nxt    = br_taken ? br_pc : flush_pc;
          state_nxt = halt ? HALTED : FETCH;
        end
      end

      HOLD: begin
        if (br_taken) begin
          pc_nxt          = br_pc;
          instr_valid_nxt = 1'b0;
          skid_valid_nxt  = 1'b0;
          state_nxt       = FETCH;
        end else if (instr_ready) begin
          instr_nxt       = skid_instr;
          instr_pc_nxt    = skid_pc;
          instr_valid_nxt = 1'b1;
          skid_valid_nxt  = 1'b0;
          state_nxt       = halt ? HALTED : FETCH;
        end
      end

      HALTED: begin
        if (br_taken) begin
          pc_nxt          = br_pc;
          instr_valid_nxt = 1'b0;
          skid_valid_nxt  = 1'b0;
        end else if (!halt) begin
          state_nxt = FETCH;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      flush_pc    <= RESET_PC;
      instr       <= 32'h0;
      instr_pc    <= 32'h0;
      instr_valid <= 1'b0;
      skid_valid  <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      flush_pc    <= flush_pc_nxt;
      instr       <= instr_nxt;
      instr_pc    <= instr_pc_nxt;
      instr_valid <= instr_valid_nxt;
      skid_valid  <= skid_valid_nxt;
    end
  end

  // NOTE: the skid payload is storage qualified by skid_valid, so it carries
  // no reset; only the valid flag needs a defined value out of reset.
  always_ff @(posedge clk) begin
    if (skid_load) begin
      skid_instr <= in_mem;
      skid_pc    <= pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit. A default instance (RESET_PC=0) covers
//   reset, streaming, wait states, back-pressure and redirect; a second
//   instance with RESET_PC=0xFFFF_FFF8 covers PC wrap and halt. Memory returns
//   addr ^ 0xA5A5_0000; inputs change 1 time unit after the rising edge and
//   outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] PAT = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_mem_ack, br_taken, halt, instr_ready;
  logic [31:0] br_target;

  logic [31:0] in_mem, in_mem_addr, instr, instr_pc;
  logic        in_mem_en, instr_valid;
  logic [31:0] w_in_mem, w_in_mem_addr, w_instr, w_instr_pc;
  logic        w_in_mem_en, w_instr_valid;

  int n_pass  = 0;
  int n_total = 0;

  assign in_mem   = in_mem_addr ^ PAT;
  assign w_in_mem = w_in_mem_addr ^ PAT;

  always #5 clk = ~clk;

  fetch_unit u_dut (
    .clk(clk), .reset(reset), .in_mem(in_mem), .in_mem_ack(in_mem_ack),
    .in_mem_addr(in_mem_addr), .in_mem_en(in_mem_en), .br_taken(br_taken),
    .br_target(br_target), .halt(halt), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .PC_STEP(32'd4)) u_wrap (
    .clk(clk), .reset(reset), .in_mem(w_in_mem), .in_mem_ack(in_mem_ack),
    .in_mem_addr(w_in_mem_addr), .in_mem_en(w_in_mem_en), .br_taken(br_taken),
    .br_target(br_target), .halt(halt), .instr_ready(instr_ready),
    .instr(w_instr), .instr_pc(w_instr_pc), .instr_valid(w_instr_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset held for 3 cycles, released 1 unit after an edge (DUT then in IDLE).
  task automatic apply_reset(input logic ack, input logic rdy);
    in_mem_ack  = ack;
    instr_ready = rdy;
    br_taken    = 1'b0;
    br_target   = 32'h0;
    halt        = 1'b0;
    reset       = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    in_mem_ack = 1'b0; instr_ready = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    halt = 1'b0; reset = 1'b0;
    repeat (3) tick();
    n_total++;
    if ({in_mem_en, in_mem_addr, instr, instr_pc, instr_valid} !== 98'h0)
      $display("FAIL reset_outputs: en=%b addr=%h instr=%h pc=%h valid=%b, want all 0",
               in_mem_en, in_mem_addr, instr, instr_pc, instr_valid);
    else n_pass++;
    n_total++;
    if ({w_in_mem_en, w_in_mem_addr} !== {1'b0, 32'hFFFF_FFF8})
      $display("FAIL reset_wrap_addr: en=%b addr=%h, want 0/fffffff8", w_in_mem_en, w_in_mem_addr);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_total++;
    if (in_mem_en !== 1'b0)
      $display("FAIL reset_idle_en: en=%b, want 0", in_mem_en);
    else n_pass++;
    tick();
    n_total++;
    if ({in_mem_en, in_mem_addr, instr_valid} !== {1'b1, 32'h0, 1'b0})
      $display("FAIL reset_first_req: en=%b addr=%h valid=%b, want 1/00000000/0",
               in_mem_en, in_mem_addr, instr_valid);
    else n_pass++;
  endtask

  task automatic test_streaming();
    logic [31:0] exp_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    apply_reset(1'b1, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++;
      if ({instr_valid, instr_pc, instr} !== {1'b1, exp_pc[i], exp_pc[i] ^ PAT})
        $display("FAIL stream_%0d: valid=%b pc=%h instr=%h, want 1/%h/%h",
                 i, instr_valid, instr_pc, instr, exp_pc[i], exp_pc[i] ^ PAT);
      else n_pass++;
    end
  endtask

  task automatic test_wait_states();
    apply_reset(1'b1, 1'b1);
    tick();
    tick();
    n_total++;
    if ({instr_valid, instr_pc} !== {1'b1, 32'h0})
      $display("FAIL wait_first: valid=%b pc=%h, want 1/00000000", instr_valid, instr_pc);
    else n_pass++;
    in_mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) in_mem_ack = 1'b1;
      n_total++;
      if ({in_mem_en, in_mem_addr} !== {1'b1, 32'h4})
        $display("FAIL wait_req_%0d: en=%b addr=%h, want 1/00000004", i, in_mem_en, in_mem_addr);
      else n_pass++;
      if (i > 0) begin
        n_total++;
        if (instr_valid !== 1'b0)
          $display("FAIL wait_valid_%0d: valid=%b, want 0", i, instr_valid);
        else n_pass++;
      end
      tick();
    end
    n_total++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h4, 32'hA5A5_0004})
      $display("FAIL wait_data: valid=%b pc=%h instr=%h, want 1/00000004/a5a50004",
               instr_valid, instr_pc, instr);
    else n_pass++;
  endtask

  task automatic test_back_pressure();
    apply_reset(1'b1, 1'b1);
    repeat (4) tick();
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h8, 32'hA5A5_0008})
        $display("FAIL bp_hold_out_%0d: valid=%b pc=%h instr=%h, want 1/00000008/a5a50008",
                 i, instr_valid, instr_pc, instr);
      else n_pass++;
      if (i > 0) begin
        n_total++;
        if ({in_mem_en, in_mem_addr} !== {1'b0, 32'h10})
          $display("FAIL bp_hold_en_%0d: en=%b addr=%h, want 0/00000010", i, in_mem_en, in_mem_addr);
        else n_pass++;
      end
      tick();
    end
    instr_ready = 1'b1;
    n_total++;
    if ({in_mem_en, instr_valid, instr_pc} !== {1'b0, 1'b1, 32'h8})
      $display("FAIL bp_still_hold: en=%b valid=%b pc=%h, want 0/1/00000008",
               in_mem_en, instr_valid, instr_pc);
    else n_pass++;
    tick();
    n_total++;
    if ({instr_valid, instr_pc, instr, in_mem_en, in_mem_addr} !==
        {1'b1, 32'hC, 32'hA5A5_000C, 1'b1, 32'h10})
      $display("FAIL bp_skid_out: valid=%b pc=%h instr=%h en=%b addr=%h, want 1/0000000c/a5a5000c/1/00000010",
               instr_valid, instr_pc, instr, in_mem_en, in_mem_addr);
    else n_pass++;
    tick();
    n_total++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h10, 32'hA5A5_0010})
      $display("FAIL bp_resume: valid=%b pc=%h instr=%h, want 1/00000010/a5a50010",
               instr_valid, instr_pc, instr);
    else n_pass++;
  endtask

  task automatic test_redirect();
    apply_reset(1'b1, 1'b1);
    repeat (9) tick();
    n_total++;
    if ({in_mem_addr, instr_valid, instr_pc} !== {32'h20, 1'b1, 32'h1C})
      $display("FAIL br_pre: addr=%h valid=%b pc=%h, want 00000020/1/0000001c",
               in_mem_addr, instr_valid, instr_pc);
    else n_pass++;
    in_mem_ack = 1'b0;
    br_taken   = 1'b1;
    br_target  = 32'h103;
    tick();
    br_taken = 1'b0;
    n_total++;
    if ({instr_valid, in_mem_en, in_mem_addr} !== {1'b0, 1'b1, 32'h20})
      $display("FAIL br_flush_0: valid=%b en=%b addr=%h, want 0/1/00000020",
               instr_valid, in_mem_en, in_mem_addr);
    else n_pass++;
    tick();
    in_mem_ack = 1'b1;
    n_total++;
    if ({instr_valid, in_mem_en, in_mem_addr} !== {1'b0, 1'b1, 32'h20})
      $display("FAIL br_flush_1: valid=%b en=%b addr=%h, want 0/1/00000020",
               instr_valid, in_mem_en, in_mem_addr);
    else n_pass++;
    tick();
    n_total++;
    if ({instr_valid, in_mem_en, in_mem_addr} !== {1'b0, 1'b1, 32'h100})
      $display("FAIL br_target_req: valid=%b en=%b addr=%h, want 0/1/00000100",
               instr_valid, in_mem_en, in_mem_addr);
    else n_pass++;
    tick();
    n_total++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h100, 32'hA5A5_0100})
      $display("FAIL br_target_data: valid=%b pc=%h instr=%h, want 1/00000100/a5a50100",
               instr_valid, instr_pc, instr);
    else n_pass++;
  endtask

  task automatic test_halt_wrap();
    logic [31:0] exp_pc [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
    apply_reset(1'b1, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if ({w_instr_valid, w_instr_pc, w_instr} !== {1'b1, exp_pc[i], exp_pc[i] ^ PAT})
        $display("FAIL wrap_%0d: valid=%b pc=%h instr=%h, want 1/%h/%h",
                 i, w_instr_valid, w_instr_pc, w_instr, exp_pc[i], exp_pc[i] ^ PAT);
      else n_pass++;
    end
    in_mem_ack = 1'b0;
    halt       = 1'b1;
    tick();
    n_total++;
    if ({w_in_mem_en, w_in_mem_addr, w_instr_valid} !== {1'b1, 32'h4, 1'b0})
      $display("FAIL halt_inflight: en=%b addr=%h valid=%b, want 1/00000004/0",
               w_in_mem_en, w_in_mem_addr, w_instr_valid);
    else n_pass++;
    in_mem_ack = 1'b1;
    tick();
    n_total++;
    if ({w_in_mem_en, w_instr_valid, w_instr_pc, w_instr} !== {1'b0, 1'b1, 32'h4, 32'hA5A5_0004})
      $display("FAIL halt_kept: en=%b valid=%b pc=%h instr=%h, want 0/1/00000004/a5a50004",
               w_in_mem_en, w_instr_valid, w_instr_pc, w_instr);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_total++;
      if ({w_in_mem_en, w_in_mem_addr, w_instr_valid} !== {1'b0, 32'h8, 1'b0})
        $display("FAIL halt_frozen_%0d: en=%b addr=%h valid=%b, want 0/00000008/0",
                 i, w_in_mem_en, w_in_mem_addr, w_instr_valid);
      else n_pass++;
    end
    halt = 1'b0;
    tick();
    n_total++;
    if ({w_in_mem_en, w_in_mem_addr} !== {1'b1, 32'h8})
      $display("FAIL halt_resume_req: en=%b addr=%h, want 1/00000008", w_in_mem_en, w_in_mem_addr);
    else n_pass++;
    tick();
    n_total++;
    if ({w_instr_valid, w_instr_pc, w_instr} !== {1'b1, 32'h8, 32'hA5A5_0008})
      $display("FAIL halt_resume_data: valid=%b pc=%h instr=%h, want 1/00000008/a5a50008",
               w_instr_valid, w_instr_pc, w_instr);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_wait_states();
    test_back_pressure();
    test_redirect();
    test_halt_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage placed directly upstream of instruction decode in the single-cycle core. It owns the PC, issues word requests to instruction memory over a request/acknowledge handshake that tolerates wait states, and presents each fetched instruction with its PC to decode over a valid/ready handshake. It also accepts taken-branch redirects from execute and a halt request, and contains a one-entry skid buffer so decode back-pressure never drops a returned word.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
PC_STEP, 4, byte increment between sequential fetches

Ports:
clk  input  1  main clock, rising edge
reset  input  1  asynchronous, active-low reset; 0 = in reset
in_mem  input  32  instruction word from instruction memory, valid when in_mem_ack=1
in_mem_ack  input  1  memory returns in_mem for the outstanding request this cycle
in_mem_addr  output  32  fetch address, word aligned
in_mem_en  output  1  fetch request
br_taken  input  1  single-cycle redirect pulse from execute
br_target  input  32  redirect address; bits [1:0] ignored and forced to 0
halt  input  1  level; stop issuing new fetches
instr_ready  input  1  decode accepts instr this cycle
instr  output  32  fetched instruction
instr_pc  output  32  address of instr
instr_valid  output  1  instr/instr_pc valid

Behaviour:
- Reset (reset=0, async): pc=RESET_PC, state=IDLE, in_mem_en=0, in_mem_addr=RESET_PC, instr=0, instr_pc=0, instr_valid=0, skid empty.
- States: IDLE, FETCH, FLUSH, HOLD, HALTED. IDLE lasts exactly one cycle after reset release, then goes to FETCH (HALTED if halt=1).
- in_mem_en=1 only in FETCH and FLUSH; in_mem_addr=pc at all times. While en=1 and ack=0, en and addr must stay stable. Memory ack can arrive in the same cycle as the request (zero-wait).
- FETCH with ack=1 and no br_taken: the word goes to the output register if it is empty or being consumed this cycle (instr_valid & instr_ready); otherwise it goes to the skid buffer and the next state is HOLD.
  - Either way, pc <= pc+PC_STEP, and the captured instr_pc is the old pc.
  - Zero-wait memory with instr_ready=1 gives one instruction per cycle. Fetch-to-valid latency is 1 cycle after ack.
- HOLD: en=0. When instr_ready=1, the skid entry moves to the output, then go to FETCH (HALTED if halt=1).
- Output handshake: a transfer occurs on instr_valid & instr_ready. instr and instr_pc hold stable while valid=1 and ready=0. valid clears after a transfer unless new data loads.
- Redirect (br_taken=1) has priority over halt and over all data movement:
  - pc <= {br_target[31:2],2'b00}.
  - instr_valid <= 0, and the skid is emptied. A simultaneous valid&ready handshake does not count as a transfer.
  - If a request is outstanding with ack=0, go to FLUSH: en stays high at the old address until ack, the returned data is discarded, then go to FETCH at the new pc.
  - If ack=1 in the same cycle as br_taken, the data is discarded and the next state is FETCH, requesting the target.
  - In HALTED, the pc and flush updates occur but the state remains HALTED.
- halt=1 in FETCH:
  - An outstanding request (ack=0) completes normally first, and its data is kept.
  - After that completion, or immediately if no request is outstanding, go to HALTED: en=0, pc frozen, and the output still drains.
  - halt=0 in HALTED returns to FETCH next cycle.
  - A br_taken pulse during FLUSH replaces the pending target; the flush itself continues.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no error.
- Reset asserted mid-request: immediate return to reset values. The ack for the abandoned request is not expected by memory.

Test Plan:
- Reset: hold reset=0 3 cycles, release -> outputs all 0, in_mem_addr=0; en rises the cycle after IDLE with addr 0x0.
- Streaming: ack tied 1, instr_ready=1, in_mem=addr^0xA5A5_0000 -> instr_valid every cycle with instr_pc 0x0,0x4,0x8,0xC in order and matching data.
- Wait states: ack delayed 3 cycles on the request at 0x4 -> en=1 and addr=0x4 stable for 4 cycles; instr_pc=0x4 valid one cycle after ack.
- Back-pressure: instr_ready=0 for 4 cycles with zero-wait memory -> output plus skid fill, state HOLD, en=0; after release, 0x8 then 0xC emerge with none lost or duplicated, and fetch resumes at 0x10.
- Redirect: br_taken with br_target=0x103 while 0x20 awaits ack (ack 2 cycles later) -> instr_valid=0 at once, en held at 0x20 until ack, data dropped, next request 0x100, next instr_pc=0x100.
- Halt and wrap: RESET_PC=0xFFFF_FFF8 -> instr_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0. Assert halt -> en=0 after the in-flight request, pc frozen; deassert -> fetch resumes at the frozen pc.
